// File: rtl/avmm_seq_master.sv
// Avalon-MM sequencing master: one command expands into a multi-beat read,
// write or fill sequence, with a bounded number of pipelined reads in flight.
module avmm_seq_master #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                clk_clk,
    input  logic                clk_reset_reset,
    output logic                master_reset_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [LEN_W-1:0]    cmd_length,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   master_address,
    output logic                master_read,
    output logic                master_write,
    output logic [DATA_W-1:0]   master_writedata,
    output logic [DATA_W/8-1:0] master_byteenable,
    input  logic                master_waitrequest,
    input  logic [DATA_W-1:0]   master_readdata,
    input  logic                master_readdatavalid
);
    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(BYTES - 1));
    localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_NOP   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [3:0]          pend_q, pend_d;
    logic                mread_q, mread_d;
    logic                mwrite_q, mwrite_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rdv_q, rdv_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mrst_q;

    logic wr_acc, rd_acc, rd_ret, can_load, load, issue;

    // Every handshake (cmd, wr, bus) completes on a rising edge where the
    // initiator's valid/strobe is high and the target is ready (waitrequest low).
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        fill_d   = fill_q;
        mread_d  = mread_q;
        mwrite_d = mwrite_q;
        wdata_d  = wdata_q;
        issue    = 1'b0;

        cmd_ready = (state_q == S_IDLE) && !mrst_q;
        wr_acc    = mwrite_q && !master_waitrequest;
        rd_acc    = mread_q && !master_waitrequest;
        rd_ret    = master_readdatavalid && (pend_q != 4'd0);
        pend_d    = pend_q + {3'b000, rd_acc} - {3'b000, rd_ret};
        can_load  = (state_q == S_WRITE) && (cnt_q < len_q) &&
                    (!mwrite_q || !master_waitrequest);
        wr_ready  = can_load && (op_q == OP_WRITE);
        load      = can_load && ((op_q != OP_WRITE) || wr_valid);

        rdv_d   = rd_ret;
        rdata_d = rd_ret ? master_readdata : rdata_q;

        if (wr_acc || rd_acc) begin
            addr_d = addr_q + ADDR_STEP;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d = cmd_address & ADDR_MASK;
                    len_d  = cmd_length;
                    op_d   = cmd_op;
                    fill_d = cmd_data;
                    cnt_d  = '0;
                    if (cmd_length == '0 || cmd_op == OP_NOP) begin
                        state_d = S_DONE;
                    end else if (cmd_op == OP_READ) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!mwrite_q || !master_waitrequest) begin
                    mwrite_d = load;
                    if (load) begin
                        wdata_d = (op_q == OP_WRITE) ? wr_data : fill_q;
                        cnt_d   = cnt_q + LEN_W'(1);
                    end
                end
                if (wr_acc && cnt_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                // The bound uses next-cycle pending so an accepted read never overshoots.
                if (!mread_q || !master_waitrequest) begin
                    issue   = (cnt_q < len_q) && (pend_d < PEND_MAX);
                    mread_d = issue;
                    if (issue) begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
                if (rd_acc && cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pend_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
        if (clk_reset_reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            fill_q   <= '0;
            pend_q   <= '0;
            mread_q  <= 1'b0;
            mwrite_q <= 1'b0;
            wdata_q  <= '0;
            rdv_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            fill_q   <= fill_d;
            pend_q   <= pend_d;
            mread_q  <= mread_d;
            mwrite_q <= mwrite_d;
            wdata_q  <= wdata_d;
            rdv_q    <= rdv_d;
            rdata_q  <= rdata_d;
        end
    end

    // Slave reset asserts with ours and releases on the first clock edge after.
    always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
        if (clk_reset_reset) begin
            mrst_q <= 1'b1;
        end else begin
            mrst_q <= 1'b0;
        end
    end

    assign master_reset_reset = mrst_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign rd_valid           = rdv_q;
    assign rd_data            = rdata_q;
    assign master_address     = addr_q;
    assign master_read        = mread_q;
    assign master_write       = mwrite_q;
    assign master_writedata   = wdata_q;
    assign master_byteenable  = '1;

endmodule
